// File: rtl/mux4x1_rr_arbiter_pkg.sv
// Shared constants, state encoding and round-robin search helper for the mux4x1 arbiter.
package mux_ctrl_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns {found, index} of the first set bit of req, searching start, start+1, ... mod NUM_REQ.
  function automatic logic [SEL_W:0] rr_search(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   start);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface mux4x1_rr_arbiter_if;
  import mux_ctrl_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               out;
  logic               out_valid;
  logic               busy;

  modport master (output req, din, input gnt, sel, out, out_valid, busy);
  modport slave  (input req, din, output gnt, sel, out, out_valid, busy);
endinterface

// File: rtl/mux4x1.sv
// Plain 4:1 one-bit multiplexer used as the shared datapath.
module mux4x1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s0,
  input  logic s1,
  output logic y
);
  always_comb begin
    y = 1'b0;
    case ({s1, s0})
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end
endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter with per-owner hold limit driving the selects of a shared mux4x1.
module mux4x1_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD) + 1
) (
  input logic               clk,
  input logic               rst,
  mux4x1_rr_arbiter_if.slave bus
);

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [HOLD_W-1:0]  hold_cnt_q;

  logic [NUM_REQ-1:0] others;
  logic               at_limit;
  logic               keep;
  logic [SEL_W-1:0]   ptr_d;
  logic [SEL_W:0]     pick_idle;
  logic [SEL_W:0]     pick_move;
  logic               mux_y;

  // Release decision for the current owner (sel_q) and the two candidate searches.
  always_comb begin
    others    = bus.req & ~(NUM_REQ'(1) << sel_q);
    at_limit  = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    keep      = bus.req[sel_q] && (!at_limit || (others == '0));
    ptr_d     = sel_q + SEL_W'(1);
    pick_idle = rr_search(bus.req, ptr_q);
    pick_move = rr_search(others, ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_idle[SEL_W]) begin
            state_q    <= ST_GRANT;
            sel_q      <= pick_idle[SEL_W-1:0];
            gnt_q      <= NUM_REQ'(1) << pick_idle[SEL_W-1:0];
            hold_cnt_q <= '0;
          end
        end
        ST_GRANT: begin
          if (keep) begin
            // A lone owner at the limit starts a fresh hold window.
            hold_cnt_q <= at_limit ? '0 : hold_cnt_q + HOLD_W'(1);
          end else begin
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
            if (pick_move[SEL_W]) begin
              sel_q <= pick_move[SEL_W-1:0];
              gnt_q <= NUM_REQ'(1) << pick_move[SEL_W-1:0];
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mux4x1 u_mux (
    .a  (bus.din[0]),
    .b  (bus.din[1]),
    .c  (bus.din[2]),
    .d  (bus.din[3]),
    .s0 (sel_q[0]),
    .s1 (sel_q[1]),
    .y  (mux_y)
  );

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = |gnt_q;
  assign bus.busy      = (state_q == ST_GRANT);
  assign bus.out       = mux_y & (|gnt_q);

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed plus randomized bench for mux4x1_rr_arbiter against a cycle-level owner/ptr model.
module tb_mux4x1_rr_arbiter;

  localparam int unsigned MAX_HOLD = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference state: current owner (-1 when idle), search pointer, cycles held in this window.
  int   m_owner;
  int   m_ptr;
  int   m_held;
  int   m_sel;

  mux4x1_rr_arbiter_if bus ();

  mux4x1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First index with req set, scanning from start upward mod 4; -1 if none.
  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    logic [3:0] oth;
    int nxt;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      nxt = first_from(r, m_ptr);
      if (nxt >= 0) begin
        m_owner = nxt; m_sel = nxt; m_held = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (r[m_owner] && (m_held < int'(MAX_HOLD) || oth == 4'b0)) begin
        m_held = (m_held % int'(MAX_HOLD)) + 1;
      end else begin
        m_ptr = (m_owner + 1) % 4;
        nxt   = first_from(oth, m_ptr);
        if (nxt >= 0) begin
          m_owner = nxt; m_sel = nxt; m_held = 1;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs 1 time unit later.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    logic [3:0] exp_gnt;
    logic       exp_out;
    rst     = rs;
    bus.req = r;
    bus.din = d;
    @(posedge clk);
    model_step(r, rs);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
    exp_out = (m_owner < 0) ? 1'b0 : d[m_sel];
    chk("gnt",       32'(bus.gnt),       32'(exp_gnt));
    chk("sel",       32'(bus.sel),       32'(m_sel));
    chk("out_valid", 32'(bus.out_valid), 32'(m_owner >= 0));
    chk("busy",      32'(bus.busy),      32'(m_owner >= 0));
    chk("out",       32'(bus.out),       32'(exp_out));
  endtask

  initial begin
    int         order [5];
    logic [3:0] r;
    logic [3:0] prev_gnt;
    int         dwell;
    order    = '{0, 1, 2, 3, 0};
    checks   = 0;
    errors   = 0;
    m_owner  = -1; m_ptr = 0; m_held = 0; m_sel = 0;
    rst      = 1'b1;
    bus.req  = 4'h0;
    bus.din  = 4'h0;

    // Reset held two cycles with all requesters active.
    for (int i = 0; i < 2; i++) begin
      step(4'hF, 4'($urandom), 1'b1);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_out", 32'(bus.out), 32'h0);
    end

    // Single requester on input c.
    step(4'b0100, 4'b0100, 1'b0);
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    chk("single_sel", 32'(bus.sel), 32'd2);
    chk("single_out", 32'(bus.out), 32'd1);
    step(4'b0000, 4'b0100, 1'b0);
    chk("idle_sel_hold", 32'(bus.sel), 32'd2);
    chk("idle_busy",     32'(bus.busy), 32'd0);

    // Round robin with wrap: each owner drops its request after one grant cycle.
    step(4'h0, 4'h0, 1'b1);
    prev_gnt = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step(4'hF & ~prev_gnt, 4'($urandom), 1'b0);
      chk("rr_order", 32'(bus.sel), 32'(order[i]));
      prev_gnt = bus.gnt;
    end

    // Hold limit: two contending requesters alternate in MAX_HOLD-cycle windows.
    step(4'h0, 4'h0, 1'b1);
    for (int k = 0; k < 4 * int'(MAX_HOLD); k++) begin
      step(4'b0011, 4'($urandom), 1'b0);
      chk("hold_gnt", 32'(bus.gnt), ((k / int'(MAX_HOLD)) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Lone owner keeps the grant across the hold-limit boundary.
    for (int k = 0; k < 20; k++) begin
      step(4'b1000, 4'($urandom), 1'b0);
      chk("lone_gnt", 32'(bus.gnt), 32'h8);
    end

    // Reset in the middle of a grant, then search restarts from 0.
    step(4'b0010, 4'b0010, 1'b0);
    chk("mid_gnt", 32'(bus.gnt), 32'h2);
    step(4'b0010, 4'b0010, 1'b1);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    step(4'b1010, 4'b0010, 1'b0);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h2);

    // Randomized traffic: requests held for random dwell times, occasional reset.
    r = 4'h0;
    dwell = 0;
    for (int k = 0; k < 600; k++) begin
      if (dwell == 0) begin
        r     = 4'($urandom);
        dwell = int'($urandom_range(1, 14));
      end
      dwell--;
      step(r, 4'($urandom), ($urandom_range(0, 79) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
